// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one gcd engine between NUM_REQ requesters.
// A single operation is in flight at a time; the result returns to the owning requester.
module gcd_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_gcd_o,
  output logic                     eng_valid_o,
  output logic [WIDTH-1:0]         eng_a_o,
  output logic [WIDTH-1:0]         eng_b_o,
  input  logic [WIDTH-1:0]         eng_gcd_i,
  input  logic                     eng_valid_i,
  output logic                     busy_o,
  output logic [ID_W-1:0]          grant_id_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StSettle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  eng_a_q, eng_a_d;
  logic [WIDTH-1:0]  eng_b_q, eng_b_d;
  logic [WIDTH-1:0]  rsp_gcd_q, rsp_gcd_d;
  logic [ID_W-1:0]   sel_idx;
  logic              sel_found;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin : p_select
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!sel_found && req_valid_i[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    rsp_gcd_d   = rsp_gcd_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    eng_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          req_ready_o[sel_idx] = 1'b1;
          eng_a_d = req_a_i[sel_idx*WIDTH +: WIDTH];
          eng_b_d = req_b_i[sel_idx*WIDTH +: WIDTH];
          grant_d = sel_idx;
          ptr_d   = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        eng_valid_o = 1'b1;
        state_d     = StSettle;
      end
      // eng_valid_i may still show the previous result here, so it is not looked at.
      StSettle: state_d = StWait;
      StWait: begin
        if (eng_valid_i) begin
          rsp_gcd_d = eng_gcd_i;
          state_d   = StResp;
        end
      end
      StResp: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      eng_a_q   <= '0;
      eng_b_q   <= '0;
      rsp_gcd_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      eng_a_q   <= eng_a_d;
      eng_b_q   <= eng_b_d;
      rsp_gcd_q <= rsp_gcd_d;
    end
  end

  assign eng_a_o    = eng_a_q;
  assign eng_b_o    = eng_b_q;
  assign rsp_gcd_o  = rsp_gcd_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural multi-cycle gcd engine
// whose done level stays high from the previous operation.
module tb_gcd_arbiter;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned LAT = 3;

  logic           clk_i = 1'b0;
  logic           reset_ni;
  logic [N-1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0] req_a_i, req_b_i;
  logic [W-1:0]   rsp_gcd_o, eng_a_o, eng_b_o, eng_gcd_i;
  logic           eng_valid_o, eng_valid_i, busy_o;
  logic [IW-1:0]  grant_id_o;

  gcd_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_gcd_o  (rsp_gcd_o),
    .eng_valid_o(eng_valid_o),
    .eng_a_o    (eng_a_o),
    .eng_b_o    (eng_b_o),
    .eng_gcd_i  (eng_gcd_i),
    .eng_valid_i(eng_valid_i),
    .busy_o     (busy_o),
    .grant_id_o (grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  // Engine model: done level stays stale through the cycle after the start pulse.
  logic [W-1:0] ea, eb;
  int           cnt;
  bit           stale;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk_i) begin
    if (!reset_ni) begin
      eng_valid_i <= 1'b0;
      eng_gcd_i   <= '0;
      cnt         <= 0;
      stale       <= 1'b0;
    end else if (eng_valid_o) begin
      ea    <= eng_a_o;
      eb    <= eng_b_o;
      cnt   <= LAT;
      stale <= 1'b1;
    end else begin
      if (stale) begin
        eng_valid_i <= 1'b0;
        stale       <= 1'b0;
      end
      if (cnt == 1) begin
        eng_valid_i <= 1'b1;
        eng_gcd_i   <= gcd_f(ea, eb);
      end
      if (cnt != 0) cnt <= cnt - 1;
    end
  end

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  g;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  bit     keep1 = 1'b0;
  logic [N-1:0] last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk_i) begin
    logic [N-1:0] hs;
    exp_t         e;
    if (reset_ni) begin
      hs = rsp_valid_o & rsp_ready_i;
      if (hs != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got valid %b gcd %0d expected none", rsp_valid_o,
                   rsp_gcd_o);
        end else begin
          e = sb.pop_front();
          if (rsp_valid_o != (N'(1) << e.id) || rsp_gcd_o != e.g) begin
            errors++;
            $display("FAIL rsp: got valid %b gcd %0d expected owner %0d gcd %0d", rsp_valid_o,
                     rsp_gcd_o, e.id, e.g);
          end
        end
      end
    end
  end

  task automatic push(input int id, input int g);
    exp_t e;
    e.id = IW'(id);
    e.g  = W'(g);
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a_i[i*W +: W] = W'(a);
    req_b_i[i*W +: W] = W'(b);
    req_valid_i[i]    = 1'b1;
  endtask

  // One clock; accepted requesters drop their valid, requester 1 re-asserts when held.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk_i);
    acc = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    req_valid_i = (req_valid_i & ~acc) | (keep1 ? 4'b0010 : 4'b0000);
    last_acc    = acc;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_drain_left"}, sb.size(), 0);
  endtask

  task automatic wait_acc(input int idx, input string name);
    int n;
    n = 0;
    step();
    while (!last_acc[idx] && n < 60) begin
      step();
      n++;
    end
    chk({name, "_granted"}, 32'(last_acc[idx]), 1);
  endtask

  task automatic chk_zero_outputs(input string p);
    chk({p, "_req_ready"}, req_ready_o, 0);
    chk({p, "_rsp_valid"}, rsp_valid_o, 0);
    chk({p, "_eng_valid"}, eng_valid_o, 0);
    chk({p, "_eng_a"}, eng_a_o, 0);
    chk({p, "_eng_b"}, eng_b_o, 0);
    chk({p, "_rsp_gcd"}, rsp_gcd_o, 0);
    chk({p, "_busy"}, busy_o, 0);
    chk({p, "_grant_id"}, grant_id_o, 0);
  endtask

  initial begin
    int n;
    reset_ni    = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = '1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero_outputs("reset");
    reset_ni = 1'b1;
    step();

    // All four at once from pointer 0; stale done covers each later op.
    push(0, 2); push(1, 3); push(2, 6); push(3, 7);
    set_req(0, 6, 2); set_req(1, 9, 12); set_req(2, 18, 12); set_req(3, 7, 7);
    #1;
    chk("all4_first_ready", req_ready_o, 4'b0001);
    drain("all4");

    // Single request from 2 with response backpressure.
    rsp_ready_i = '0;
    push(2, 6);
    set_req(2, 18, 12);
    #1;
    chk("single_ready", req_ready_o, 4'b0100);
    chk("single_no_pulse_yet", eng_valid_o, 0);
    step();
    chk("single_pulse", eng_valid_o, 1);
    chk("single_eng_a", eng_a_o, 18);
    chk("single_eng_b", eng_b_o, 12);
    chk("single_grant", grant_id_o, 2);
    step();
    chk("single_pulse_end", eng_valid_o, 0);
    chk("single_settle_busy", busy_o, 1);
    n = 0;
    while (rsp_valid_o == '0 && n < 60) begin
      step();
      n++;
    end
    chk("single_rsp_valid", rsp_valid_o, 4'b0100);
    chk("single_rsp_gcd", rsp_gcd_o, 6);
    rsp_ready_i = 4'b1011;
    set_req(0, 5, 5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid_o, 4'b0100);
      chk("bp_rsp_gcd", rsp_gcd_o, 6);
      chk("bp_req_ready", req_ready_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    drain("single");
    chk("single_idle_busy", busy_o, 0);

    // Previous done (result 6) is still high during SETTLE.
    push(1, 3);
    set_req(1, 9, 12);
    drain("stale");

    // Fairness: pointer is now 2; requester 1 holds valid continuously.
    push(1, 4); push(3, 5); push(1, 4);
    keep1 = 1'b1;
    set_req(1, 8, 12);
    wait_acc(1, "fair_first1");
    set_req(3, 15, 25);
    wait_acc(3, "fair_then3");
    wait_acc(1, "fair_back1");
    keep1 = 1'b0;
    req_valid_i[1] = 1'b0;
    drain("fair");

    // Reset while in WAIT abandons the op and clears the pointer.
    set_req(2, 20, 30);
    step();
    step();
    step();
    chk("rst_pre_busy", busy_o, 1);
    reset_ni = 1'b0;
    step();
    chk_zero_outputs("midrst");
    reset_ni = 1'b1;
    push(0, 2); push(3, 7);
    set_req(0, 4, 6); set_req(3, 21, 14);
    #1;
    chk("postrst_ready", req_ready_o, 4'b0001);
    drain("postrst");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Shares one gcd engine between NUM_REQ requesters. Each requester uses a valid/ready handshake to submit an operand pair. The arbiter picks one pending request round-robin and issues it to the engine as a one-cycle start pulse. It then waits for the engine's result and returns it to the owning requester over a valid/ready response channel. It sits between the requester ports and the single gcd instance; only one operation is in flight at a time.

Parameters:
WIDTH, 8, operand and result width; must match the engine.
NUM_REQ, 4, number of requesters, 2..8.
ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
clk_i  in  1  clock, rising edge.
reset_ni  in  1  synchronous, active-low reset.
req_valid_i  in  NUM_REQ  per-requester request valid.
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
req_a_i  in  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
req_b_i  in  NUM_REQ*WIDTH  operand B; slice i belongs to requester i.
rsp_valid_o  out  NUM_REQ  per-requester result valid; one-hot or zero.
rsp_ready_i  in  NUM_REQ  per-requester result accept.
rsp_gcd_o  out  WIDTH  result, shared bus; meaningful only for the asserted rsp_valid_o bit.
eng_valid_o  out  1  engine start pulse.
eng_a_o  out  WIDTH  operand A to the engine.
eng_b_o  out  WIDTH  operand B to the engine.
eng_gcd_i  in  WIDTH  engine result.
eng_valid_i  in  1  engine done; level, may remain high from the previous operation.
busy_o  out  1  high in every state except IDLE.
grant_id_o  out  ID_W  index of the current or last owner.

Behaviour:
- Reset (reset_ni=0 sampled at a rising edge):
  - state = IDLE; round-robin pointer = 0.
  - All outputs 0: req_ready_o, rsp_valid_o, eng_valid_o, eng_a_o, eng_b_o, rsp_gcd_o, busy_o, grant_id_o.
  - Reset mid-operation abandons the operation with no response. The engine is reset separately by the integrator.
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, select the first set bit at or after the pointer, wrapping.
  - req_ready_o is combinational from that selection: exactly that bit is 1 in this cycle. The handshake completes in the same cycle.
  - At the edge: latch the selected requester's A/B into eng_a_o/eng_b_o, set grant_id_o, pointer = selected+1 (mod NUM_REQ), go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: eng_valid_o = 1 for exactly this cycle; go to SETTLE.
- SETTLE: eng_valid_i is ignored, since it may still reflect the previous result; go to WAIT.
- WAIT:
  - On the first cycle with eng_valid_i=1, capture eng_gcd_i into rsp_gcd_o and go to RESP.
  - No timeout.
- RESP:
  - rsp_valid_o[grant_id_o] = 1.
  - rsp_gcd_o and the rsp_valid_o bit stay stable until rsp_ready_i[grant_id_o]=1 at an edge, then go to IDLE.
  - rsp_ready_i bits of non-owners are ignored.
- Latency: request accept to rsp_valid_o is 3 cycles plus the engine's compute time. At most one request is accepted per operation; back-to-back requests need at least 5 cycles.
- Fairness:
  - The requester just served has lowest priority next time.
  - With all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0,...
- req_valid_i that drops before being accepted is simply not granted; no state is kept per requester.
- Operand values are passed through unmodified. Zero operands are legal and result handling is the engine's responsibility.
- eng_a_o/eng_b_o hold their values from ISSUE until the next accept.

Test Plan:
- Single request: requester 2 sends A=18, B=12 → req_ready_o=4'b0100 in the accept cycle; eng_valid_o is one pulse 1 cycle later; rsp_valid_o=4'b0100 with rsp_gcd_o=6; held until rsp_ready_i[2].
- All four request in the same cycle, with operand pairs (6,2), (9,12), (18,12), (7,7) → grants in order 0,1,2,3; results 2, 3, 6, 7, each on its own rsp_valid_o bit.
- Stale done: previous result 6 still on eng_valid_i=1 during SETTLE; next op (9,12) → captured result is 3, never 6.
- Backpressure: hold rsp_ready_i low 10 cycles → rsp_valid_o and rsp_gcd_o stay stable; no new req_ready_o; busy_o=1 throughout.
- Fairness: requester 1 requests continuously while requester 3 requests once after the first grant to 1 → next grant goes to 3, then back to 1.
- Reset mid-WAIT: reset_ni=0 for one cycle → all outputs 0, state IDLE, pointer 0; a new request from requester 0 is then granted normally.
